// File: rtl/approx_mult_scheduler.sv
// Round-robin scheduler that shares one combinational 8x8 approximate multiplier
// among NUM_REQ requesters through an issue stage and a backpressured response stage.
module approx_mult_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [8*NUM_REQ-1:0]   req_a,
  input  logic [8*NUM_REQ-1:0]   req_b,
  input  logic [NUM_REQ-1:0]     req_mask,
  input  logic                   cfg_force_exact,
  output logic [7:0]             mult_in1,
  output logic [7:0]             mult_in2,
  output logic                   mult_mask,
  input  logic [15:0]            mult_out,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [15:0]            rsp_product,
  input  logic                   stat_clr,
  output logic [CNT_W-1:0]       stat_approx_cnt,
  output logic                   busy
);

  logic               op_valid_q, op_valid_d;
  logic [ID_W-1:0]    op_id_q, op_id_d;
  logic [7:0]         mult_in1_q, mult_in1_d;
  logic [7:0]         mult_in2_q, mult_in2_d;
  logic               mult_mask_q, mult_mask_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
  logic [15:0]        rsp_product_q, rsp_product_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]   stat_cnt_q, stat_cnt_d;

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [2*NUM_REQ-1:0] req_rot;
  logic                 grant_found;
  logic [ID_W-1:0]      grant_id;
  int                   grant_sum;

  logic       op_move;
  logic       accept_en;
  logic       accept;
  logic [7:0] sel_a;
  logic [7:0] sel_b;
  logic       sel_mask;
  logic       eff_mask;

  // Rotating a doubled copy by ptr puts the search start at bit 0; scanning the
  // offsets downwards lets the nearest valid requester overwrite the others.
  always_comb begin
    // NOTE: every variable of a combinational block gets a default before any
    // conditional assignment, otherwise a latch is inferred for the unassigned paths.
    req_dbl     = {req_valid, req_valid};
    req_rot     = req_dbl >> ptr_q;
    grant_found = 1'b0;
    grant_id    = '0;
    grant_sum   = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        grant_found = 1'b1;
        grant_sum   = int'(ptr_q) + k;
        if (grant_sum >= NUM_REQ) grant_sum = grant_sum - NUM_REQ;
        grant_id    = ID_W'(grant_sum);
      end
    end
  end

  always_comb begin
    sel_a    = '0;
    sel_b    = '0;
    sel_mask = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_W'(i)) begin
        sel_a    = req_a[8*i +: 8];
        sel_b    = req_b[8*i +: 8];
        sel_mask = req_mask[i];
      end
    end
  end

  always_comb begin
    op_move   = op_valid_q & (~rsp_valid_q | rsp_ready);
    accept_en = ~op_valid_q | op_move;
    accept    = accept_en & grant_found;
    eff_mask  = sel_mask | cfg_force_exact;

    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (accept && grant_id == ID_W'(i)) req_ready[i] = 1'b1;
    end

    op_valid_d    = op_valid_q;
    op_id_d       = op_id_q;
    mult_in1_d    = mult_in1_q;
    mult_in2_d    = mult_in2_q;
    mult_mask_d   = mult_mask_q;
    ptr_d         = ptr_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_id_d      = rsp_id_q;
    rsp_product_d = rsp_product_q;
    stat_cnt_d    = stat_cnt_q;

    if (op_move) begin
      rsp_valid_d   = 1'b1;
      rsp_id_d      = op_id_q;
      rsp_product_d = mult_out;
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d   = 1'b0;
    end

    // Multiplier operands only toggle on accept so an idle or stalled
    // multiplier sees no input activity.
    if (accept) begin
      op_valid_d  = 1'b1;
      op_id_d     = grant_id;
      mult_in1_d  = sel_a;
      mult_in2_d  = sel_b;
      mult_mask_d = eff_mask;
      ptr_d       = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
    end else if (op_move) begin
      op_valid_d  = 1'b0;
    end

    if (stat_clr) begin
      stat_cnt_d = '0;
    end else if (accept && !eff_mask && stat_cnt_q != '1) begin
      stat_cnt_d = stat_cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_valid_q    <= 1'b0;
      op_id_q       <= '0;
      mult_in1_q    <= '0;
      mult_in2_q    <= '0;
      mult_mask_q   <= 1'b0;
      ptr_q         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= '0;
      rsp_product_q <= '0;
      stat_cnt_q    <= '0;
    end else begin
      op_valid_q    <= op_valid_d;
      op_id_q       <= op_id_d;
      mult_in1_q    <= mult_in1_d;
      mult_in2_q    <= mult_in2_d;
      mult_mask_q   <= mult_mask_d;
      ptr_q         <= ptr_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_id_q      <= rsp_id_d;
      rsp_product_q <= rsp_product_d;
      stat_cnt_q    <= stat_cnt_d;
    end
  end

  assign mult_in1        = mult_in1_q;
  assign mult_in2        = mult_in2_q;
  assign mult_mask       = mult_mask_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_id          = rsp_id_q;
  assign rsp_product     = rsp_product_q;
  assign stat_approx_cnt = stat_cnt_q;
  assign busy            = op_valid_q | rsp_valid_q;

endmodule

// File: tb/tb_approx_mult_scheduler.sv
// Directed and randomized bench for approx_mult_scheduler; a transaction-level
// model (in-flight queue, pointer, counter) predicts every output each cycle.
module tb_approx_mult_scheduler;

  localparam int N       = 4;
  localparam int ID_W    = 2;
  localparam int CNT_W   = 16;
  localparam int CNT_MAX = 65535;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [8*N-1:0]    req_a;
  logic [8*N-1:0]    req_b;
  logic [N-1:0]      req_mask;
  logic              cfg_force_exact;
  logic [7:0]        mult_in1;
  logic [7:0]        mult_in2;
  logic              mult_mask;
  logic [15:0]       mult_out;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [ID_W-1:0]   rsp_id;
  logic [15:0]       rsp_product;
  logic              stat_clr;
  logic [CNT_W-1:0]  stat_approx_cnt;
  logic              busy;

  always #5 clk = ~clk;

  approx_mult_scheduler #(.NUM_REQ(N), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_mask(req_mask),
    .cfg_force_exact(cfg_force_exact),
    .mult_in1(mult_in1), .mult_in2(mult_in2), .mult_mask(mult_mask),
    .mult_out(mult_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_product(rsp_product),
    .stat_clr(stat_clr), .stat_approx_cnt(stat_approx_cnt), .busy(busy)
  );

  // Multiplier stand-in: exact product, or product with the low nibble dropped.
  function automatic logic [15:0] prod(input logic [7:0] a, input logic [7:0] b, input logic m);
    logic [15:0] p;
    p = 16'(a) * 16'(b);
    return m ? p : (p & 16'hFFF0);
  endfunction

  always_comb mult_out = prod(mult_in1, mult_in2, mult_mask);

  typedef struct {
    int         id;
    logic [7:0] a;
    logic [7:0] b;
    logic       m;
  } op_t;

  op_t        inflight[$];
  bit         m_rsp_v;
  int         m_ptr;
  int         m_cnt;
  logic [7:0] m_in1;
  logic [7:0] m_in2;
  logic       m_mask;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    inflight.delete();
    m_rsp_v = 1'b0;
    m_ptr   = 0;
    m_cnt   = 0;
    m_in1   = '0;
    m_in2   = '0;
    m_mask  = 1'b0;
  endtask

  task automatic set_idle();
    req_valid       = '0;
    req_a           = '0;
    req_b           = '0;
    req_mask        = '0;
    cfg_force_exact = 1'b0;
    rsp_ready       = 1'b1;
    stat_clr        = 1'b0;
  endtask

  task automatic do_reset();
    set_idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Called just after a falling edge with inputs driven; checks outputs against
  // the model, then advances the model across the next rising edge.
  task automatic step();
    bit         op_v;
    bit         fire;
    bit         move;
    bit         acc_en;
    bit         acc;
    bit         clr;
    int         g;
    logic [N-1:0] exp_ready;
    op_t        it;
    #1;
    op_v   = inflight.size() > (m_rsp_v ? 1 : 0);
    fire   = m_rsp_v && rsp_ready;
    move   = op_v && (!m_rsp_v || rsp_ready);
    acc_en = !op_v || move;
    g = -1;
    for (int k = 0; k < N; k++) begin
      if (g < 0 && ((req_valid >> ((m_ptr + k) % N)) & 1) != 0) g = (m_ptr + k) % N;
    end
    acc       = acc_en && g >= 0;
    exp_ready = acc ? N'(1 << g) : '0;

    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("busy", 32'(busy), 32'(inflight.size() != 0));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_rsp_v));
    if (m_rsp_v) begin
      chk("rsp_id", 32'(rsp_id), 32'(inflight[0].id));
      chk("rsp_product", 32'(rsp_product), 32'(prod(inflight[0].a, inflight[0].b, inflight[0].m)));
    end
    chk("mult_in1", 32'(mult_in1), 32'(m_in1));
    chk("mult_in2", 32'(mult_in2), 32'(m_in2));
    chk("mult_mask", 32'(mult_mask), 32'(m_mask));
    chk("stat_cnt", 32'(stat_approx_cnt), 32'(m_cnt));

    it = '{id: 0, a: 8'h0, b: 8'h0, m: 1'b0};
    if (acc) begin
      it.id = g;
      it.a  = 8'(req_a >> (8 * g));
      it.b  = 8'(req_b >> (8 * g));
      it.m  = (((req_mask >> g) & 1) != 0) || cfg_force_exact;
    end
    clr = stat_clr;

    @(posedge clk);
    if (fire) void'(inflight.pop_front());
    m_rsp_v = move || (m_rsp_v && !fire);
    if (acc) begin
      inflight.push_back(it);
      m_ptr  = (g + 1) % N;
      m_in1  = it.a;
      m_in2  = it.b;
      m_mask = it.m;
    end
    if (clr) m_cnt = 0;
    else if (acc && !it.m && m_cnt < CNT_MAX) m_cnt++;
    @(negedge clk);
  endtask

  task automatic all_valid(input logic [N-1:0] masks);
    req_valid = '1;
    req_mask  = masks;
    req_a     = $urandom;
    req_b     = $urandom;
  endtask

  initial begin
    int iter;

    // Reset state
    set_idle();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mult_in1", 32'(mult_in1), 32'd0);
    chk("rst_stat", 32'(stat_approx_cnt), 32'd0);
    do_reset();

    // 1: single exact op from requester 0
    req_valid = 4'b0001;
    req_a     = 32'h0000_0003;
    req_b     = 32'h0000_0005;
    req_mask  = 4'b0001;
    #1;
    chk("t1_ready", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    #1;
    chk("t1_rsp_not_yet", 32'(rsp_valid), 32'd0);
    step();
    #1;
    chk("t1_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t1_rsp_id", 32'(rsp_id), 32'd0);
    chk("t1_product", 32'(rsp_product), 32'd15);
    step();
    #1;
    chk("t1_busy_falls", 32'(busy), 32'd0);

    // 2: all requesters valid, round-robin back to back
    do_reset();
    for (int i = 0; i < 6; i++) begin
      all_valid('1);
      #1;
      chk("t2_grant", 32'(req_ready), 32'(1 << (i % 4)));
      step();
    end

    // 3: stall for five cycles, then release
    for (int i = 0; i < 5; i++) begin
      all_valid('1);
      rsp_ready = 1'b0;
      #1;
      chk("t3_stall_ready", 32'(req_ready), 32'd0);
      step();
    end
    for (int i = 0; i < 8; i++) begin
      all_valid('1);
      rsp_ready = 1'b1;
      step();
    end

    // 4: forced exact vs approximate on requester 1
    do_reset();
    req_valid = 4'b0010; req_a = 32'h0000_1100; req_b = 32'h0000_0700;
    req_mask = 4'b0000; cfg_force_exact = 1'b1;
    step();
    req_valid = '0;
    #1;
    chk("t4_forced_mask", 32'(mult_mask), 32'd1);
    chk("t4_forced_cnt", 32'(stat_approx_cnt), 32'd0);
    step(); step();
    req_valid = 4'b0010; cfg_force_exact = 1'b0;
    step();
    req_valid = '0;
    #1;
    chk("t4_approx_mask", 32'(mult_mask), 32'd0);
    chk("t4_approx_cnt", 32'(stat_approx_cnt), 32'd1);
    step(); step();

    // 5: drive the counter to 0xFFFE, saturate, then clear against an accept
    iter = 0;
    while (m_cnt < 16'hFFFE && iter < 70000) begin
      all_valid('0);
      step();
      iter++;
    end
    #1;
    chk("t5_cnt_fffe", 32'(stat_approx_cnt), 32'hFFFE);
    for (int i = 0; i < 3; i++) begin
      all_valid('0);
      step();
    end
    #1;
    chk("t5_cnt_sat", 32'(stat_approx_cnt), 32'hFFFF);
    all_valid('0);
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    #1;
    chk("t5_cnt_clr", 32'(stat_approx_cnt), 32'd0);

    // Randomized traffic with backpressure and occasional clears
    for (int i = 0; i < 400; i++) begin
      req_valid       = N'($urandom);
      req_a           = $urandom;
      req_b           = $urandom;
      req_mask        = N'($urandom);
      cfg_force_exact = ($urandom_range(0, 3) == 0);
      rsp_ready       = ($urandom_range(0, 2) != 0);
      stat_clr        = ($urandom_range(0, 49) == 0);
      step();
    end

    // 6: reset mid-stream, then search restarts at requester 0
    set_idle();
    for (int i = 0; i < 3; i++) begin
      all_valid('0);
      step();
    end
    #2;
    rst_n     = 1'b0;
    req_valid = '0;
    #1;
    chk("t6_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t6_rsp_id", 32'(rsp_id), 32'd0);
    chk("t6_rsp_product", 32'(rsp_product), 32'd0);
    chk("t6_mult_in1", 32'(mult_in1), 32'd0);
    chk("t6_mult_in2", 32'(mult_in2), 32'd0);
    chk("t6_mult_mask", 32'(mult_mask), 32'd0);
    chk("t6_stat", 32'(stat_approx_cnt), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_req_ready", 32'(req_ready), 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    all_valid('1);
    #1;
    chk("t6_first_grant", 32'(req_ready), 32'h1);
    for (int i = 0; i < 6; i++) begin
      all_valid('1);
      step();
    end
    set_idle();
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
